// File: rtl/jk_count_ctrl_if.sv
// Request/feedback bundle between a JK count controller, its requester and the JK flip-flop bank.
// The master side drives requests and the bank readback; the slave side is the controller.
interface jk_count_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q_fb;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             busy;
  logic             wrap;
  logic             err;

  modport master (
    output en, up, load, load_val, q_fb,
    input  j, k, busy, wrap, err
  );

  modport slave (
    input  en, up, load, load_val, q_fb,
    output j, k, busy, wrap, err
  );
endinterface

// File: rtl/jk_count_ctrl.sv
// Modulo-MODULUS up/down/load sequencer driving an external JK bank; one step = request edge + DRIVE + SETTLE,
// requests are dropped (not queued) while busy. Optional readback check via JK_READBACK_CHK_EN.
module jk_count_ctrl #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic           clk,
  input  logic           rst,
  jk_count_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    INIT   = 3'd0,
    CLEAR  = 3'd1,
    DRIVE  = 3'd2,
    SETTLE = 3'd3,
    IDLE   = 3'd4
  } state_t;

  localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] next_val;
  logic             step_wrap;
  logic [WIDTH-1:0] j_nxt;
  logic [WIDTH-1:0] k_nxt;
  logic [WIDTH-1:0] j_q;
  logic [WIDTH-1:0] k_q;
  logic             wrap_pend;
  logic             wrap_q;

  // Target value derived from the bank readback, not from a shadow counter.
  always_comb begin
    next_val  = bus.q_fb;
    step_wrap = 1'b0;
    if (bus.load) begin
      next_val = ({1'b0, bus.load_val} >= MOD_W) ? MAX_V : bus.load_val;
    end else if (bus.up) begin
      step_wrap = (bus.q_fb == MAX_V);
      next_val  = step_wrap ? '0 : bus.q_fb + WIDTH'(1);
    end else begin
      step_wrap = (bus.q_fb == '0);
      next_val  = step_wrap ? MAX_V : bus.q_fb - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= INIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    state_nxt = CLEAR;
      CLEAR:   state_nxt = SETTLE;
      DRIVE:   state_nxt = SETTLE;
      SETTLE:  state_nxt = IDLE;
      IDLE:    if (bus.load || bus.en) state_nxt = DRIVE;
      default: state_nxt = INIT;
    endcase
  end

  // Excitation is decoded from the state being entered so j/k are registered alongside it.
  always_comb begin
    j_nxt = '0;
    k_nxt = '0;
    case (state_nxt)
      CLEAR: k_nxt = '1;
      DRIVE: begin
        j_nxt = next_val & ~bus.q_fb;
        k_nxt = ~next_val & bus.q_fb;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      j_q       <= '0;
      k_q       <= '0;
      wrap_pend <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      j_q    <= j_nxt;
      k_q    <= k_nxt;
      if (state == IDLE) begin
        wrap_pend <= !bus.load && bus.en && step_wrap;
      end
      wrap_q <= (state == DRIVE) && wrap_pend;
    end
  end

  assign bus.j    = j_q;
  assign bus.k    = k_q;
  assign bus.busy = (state != IDLE);
  assign bus.wrap = wrap_q;

`ifdef JK_READBACK_CHK_EN
  // The expected value only has an observer when the readback check exists.
  logic [WIDTH-1:0] exp_val;
  logic             err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_val <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state == CLEAR) begin
        exp_val <= '0;
      end else if (state_nxt == DRIVE) begin
        exp_val <= next_val;
      end
      if ((state == SETTLE) && (bus.q_fb != exp_val)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: doc/jk_count_ctrl.md
JK_COUNT_CTRL -- requirements
Module: jk_count_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4, JK bank width in bits.
REQ-002 SHALL have parameter MODULUS, default 10, count modulus (2 <= MODULUS <= 2^WIDTH).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en  input  1  step request, sampled in IDLE only.
REQ-006 SHALL have port up  input  1  direction, 1 = up, 0 = down, sampled with en.
REQ-007 SHALL have port load  input  1  load request, sampled in IDLE only, priority over en.
REQ-008 SHALL have port load_val  input  WIDTH  value to load.
REQ-009 SHALL have port q_fb  input  WIDTH  q outputs of downstream JK flip-flop bank.
REQ-010 SHALL have port j  output  WIDTH  registered J drives to JK bank.
REQ-011 SHALL have port k  output  WIDTH  registered K drives to JK bank.
REQ-012 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-013 SHALL have port wrap  output  1  one-cycle pulse when a step wraps modulo MODULUS.
REQ-014 SHALL have port err  output  1  sticky readback mismatch flag.

Function
REQ-015 SHALL implement states INIT, CLEAR, DRIVE, SETTLE, IDLE.
REQ-016 SHALL transition INIT -> CLEAR -> SETTLE -> IDLE unconditionally, one edge each.
REQ-017 SHALL drive j=0, k=all-ones during CLEAR, zeroing the JK bank at the next edge; the expected value then becomes 0.
REQ-018 In IDLE with load=1: next = load_val, clamped to MODULUS-1 if load_val >= MODULUS; go to DRIVE.
REQ-019 In IDLE with load=0, en=1, up=1: next = (q_fb == MODULUS-1) ? 0 : q_fb+1; go to DRIVE.
REQ-020 In IDLE with load=0, en=1, up=0: next = (q_fb == 0) ? MODULUS-1 : q_fb-1; go to DRIVE.
REQ-021 In IDLE with load=0, en=0: remain in IDLE, j=k=0.
REQ-022 SHALL register per-bit excitation j = next & ~q_fb, k = ~next & q_fb, valid only during DRIVE.
REQ-023 SHALL transition DRIVE -> SETTLE -> IDLE, one edge each; j=k=0 in SETTLE, IDLE, INIT.
REQ-024 SHALL complete one step in 3 cycles: request edge, DRIVE cycle, SETTLE cycle.
REQ-025 SHALL ignore (not queue) en and load while busy=1.
REQ-026 SHALL pulse wrap high for the SETTLE cycle of an en step that took the wrap branch (up at MODULUS-1, down at 0); loads never assert wrap.
REQ-027 SHALL store the expected value (next) at the DRIVE entry edge.
REQ-028 SHALL NOT drive the JK bank's own rst; the integrator ties it inactive (high).

Reset
REQ-029 While rst=0: state=INIT, j=0, k=0, busy=1, wrap=0, err=0, expected=0, independent of clk.
REQ-030 Reset asserted mid-DRIVE SHALL immediately force j=k=0 and INIT; the sequence restarts with CLEAR after release.

Configuration
REQ-031 Macro JK_READBACK_CHK_EN: when defined, in SETTLE compare q_fb with the expected value; on mismatch set err=1 at the next edge, held until reset.
REQ-032 Without JK_READBACK_CHK_EN: err SHALL be constant 0; the port remains present and no comparator logic is generated.

Verification
REQ-033 Release rst with bank at 4'b1011 -> cycle 2 j=0000, k=1111; in IDLE q_fb=0, busy=0.
REQ-034 MODULUS=10, q=9, en=1 up=1 -> DRIVE j=0000 k=1001; q becomes 0; wrap=1 in SETTLE.
REQ-035 q=0, en=1 up=0 -> next 9, j=1001 k=0000, wrap=1; q=5 down -> 4, wrap=0.
REQ-036 load=1 load_val=12, en=1 -> loads 9 (clamped), wrap=0; load asserted during busy is ignored.
REQ-037 JK_READBACK_CHK_EN defined, bank q bit0 forced stuck-at-0 on a step 2 -> 3 -> err=1 after SETTLE, stays 1 until rst=0.
REQ-038 rst pulsed low during DRIVE -> j=k=0 asynchronously, then INIT/CLEAR/SETTLE/IDLE, q_fb=0.
